// File: rtl/tile_pkg.sv
// rtl/tile_pkg.sv - shared types and constants for the tile composer
package tile_pkg;
    localparam int TILE_DIM = 16;
    localparam int PIX_W    = 8;
    localparam int ROW_W    = 128;

    typedef struct packed {
        logic       draw;
        logic       flush;
        logic [4:0] sx;
        logic [4:0] sy;
        logic [7:0] z;
        logic [7:0] tex;
        logic [5:0] tx;
        logic [5:0] ty;
    } cmd_entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAW  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // pos+16-off in 6 bits; only values with the top two bits clear land inside the texture
    function automatic logic [5:0] win_idx(input logic [3:0] pos, input logic [4:0] off);
        return {2'b00, pos} + 6'd16 - {1'b0, off};
    endfunction
endpackage

// File: rtl/tile_cmd_fifo.sv
// rtl/tile_cmd_fifo.sv - command FIFO with show-ahead read (head valid on the pop cycle)
module tile_cmd_fifo
    import tile_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  cmd_entry_t push_data,
    input  logic       pop,
    output cmd_entry_t pop_data,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(DEPTH);

    cmd_entry_t  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_pop;
    logic        do_push;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop   = pop && !empty;
    // a full FIFO still takes a write when the head leaves in the same cycle
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end
endmodule

// File: rtl/tile_composer.sv
// rtl/tile_composer.sv - composes 16x16 tiles from layered texture rows and flushes them to framebuffer
module tile_composer
    import tile_pkg::*;
#(
    parameter int FIFO_DEPTH = 64,
    parameter int TILE_COLS  = 40,
    parameter int TILE_ROWS  = 30
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_calc_ena,
    input  logic [4:0]   i_calc_start_x,
    input  logic [4:0]   i_calc_start_y,
    input  logic [7:0]   i_calc_position_z,
    input  logic [7:0]   i_texture_idx,
    input  logic [5:0]   i_current_tile_x,
    input  logic [5:0]   i_current_tile_y,
    input  logic         i_sm_render_done,
    output logic [11:0]  o_tex_addr,
    input  logic [127:0] i_tex_row,
    output logic         o_fb_we,
    output logic [14:0]  o_fb_addr,
    output logic [127:0] o_fb_data,
    input  logic         i_fb_ready,
    output logic         o_busy,
    output logic         o_overflow
);
    cmd_entry_t       push_entry;
    cmd_entry_t       head;
    cmd_entry_t       cur;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [5:0]       last_tx;
    logic [5:0]       last_ty;
    state_t           state;
    logic [4:0]       cnt;
    logic [ROW_W-1:0] tile_buf [TILE_DIM];
    logic [PIX_W-1:0] zbuf [TILE_DIM][TILE_DIM];
    logic             mrg_valid;
    logic [3:0]       mrg_row;
    logic [5:0]       sr;
    logic             row_hit;
    logic             fb_ok;
    logic             flushing;
    logic [14:0]      fb_addr;
    logic [5:0]       col [TILE_DIM];
    logic [PIX_W-1:0] texel [TILE_DIM];
    logic [TILE_DIM-1:0] pix_we;

    assign fifo_push = i_calc_ena | i_sm_render_done;
    assign fifo_pop  = (state == IDLE) && !fifo_empty;

    // flush-only entries inherit the tile of the most recent draw
    always_comb begin
        push_entry.draw  = i_calc_ena;
        push_entry.flush = i_sm_render_done;
        push_entry.sx    = i_calc_start_x;
        push_entry.sy    = i_calc_start_y;
        push_entry.z     = i_calc_position_z;
        push_entry.tex   = i_texture_idx;
        push_entry.tx    = i_calc_ena ? i_current_tile_x : last_tx;
        push_entry.ty    = i_calc_ena ? i_current_tile_y : last_ty;
    end

    tile_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign sr         = win_idx(cnt[3:0], cur.sy);
    assign row_hit    = (state == DRAW) && !cnt[4] && (sr[5:4] == 2'b00);
    assign o_tex_addr = row_hit ? {cur.tex, sr[3:0]} : 12'd0;

    assign fb_ok    = (32'(cur.tx) < TILE_COLS) && (32'(cur.ty) < TILE_ROWS);
    assign flushing = (state == FLUSH) && fb_ok;
    assign fb_addr  = (15'(cur.ty) * 15'd16 + 15'(cnt[3:0])) * 15'(TILE_COLS) + 15'(cur.tx);

    assign o_fb_we   = flushing;
    assign o_fb_addr = flushing ? fb_addr : 15'd0;
    assign o_fb_data = flushing ? tile_buf[cnt[3:0]] : '0;
    assign o_busy    = !fifo_empty || (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            cur        <= '0;
            last_tx    <= '0;
            last_ty    <= '0;
            mrg_valid  <= 1'b0;
            mrg_row    <= '0;
            o_overflow <= 1'b0;
        end else begin
            if (i_calc_ena) begin
                last_tx <= i_current_tile_x;
                last_ty <= i_current_tile_y;
            end
            if (fifo_push && fifo_full && !fifo_pop) o_overflow <= 1'b1;
            mrg_valid <= row_hit;
            mrg_row   <= cnt[3:0];
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        cur   <= head;
                        cnt   <= '0;
                        state <= head.draw ? DRAW : FLUSH;
                    end
                end
                DRAW: begin
                    if (cnt == 5'd16) begin
                        cnt   <= '0;
                        state <= cur.flush ? FLUSH : IDLE;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                FLUSH: begin
                    // off-screen tiles still step through all rows, just without writes
                    if (i_fb_ready || !fb_ok) begin
                        if (cnt == 5'd15) begin
                            cnt   <= '0;
                            state <= IDLE;
                        end else begin
                            cnt <= cnt + 5'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        for (int px = 0; px < TILE_DIM; px++) begin
            col[px]    = win_idx(4'(px), cur.sx);
            texel[px]  = i_tex_row[{col[px][3:0], 3'b000} +: PIX_W];
            pix_we[px] = (col[px][5:4] == 2'b00) &&
                         ((cur.z == 8'd0) ||
                          ((texel[px] != '0) && (cur.z >= zbuf[mrg_row][px])));
        end
    end

    // background layers carry z=0, so storing cur.z also resets the depth there
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < TILE_DIM; r++) begin
                tile_buf[r] <= '0;
                for (int px = 0; px < TILE_DIM; px++) zbuf[r][px] <= '0;
            end
        end else if (mrg_valid) begin
            for (int px = 0; px < TILE_DIM; px++) begin
                if (pix_we[px]) begin
                    tile_buf[mrg_row][px*PIX_W +: PIX_W] <= texel[px];
                    zbuf[mrg_row][px]                    <= cur.z;
                end
            end
        end
    end
endmodule
